// File: rtl/cpuregs_pkg.sv
// Shared constants and helpers for the banked PDP2011 register file.
// Covers processor mode encodings, special register indices, FSM states and sizing functions.
package cpuregs_pkg;

  localparam logic [1:0] KERNEL  = 2'b00;
  localparam logic [1:0] SUPER   = 2'b01;
  localparam logic [1:0] ILLEGAL = 2'b10;
  localparam logic [1:0] USER    = 2'b11;

  localparam logic [2:0] REG_SP = 3'd6;
  localparam logic [2:0] REG_PC = 3'd7;

  typedef enum logic {SCRUB, RUN} state_t;

  function automatic int nreg(input int nsets);
    return 6 * nsets + 4;
  endfunction

  function automatic int set_bits(input int nsets);
    return (nsets > 1) ? $clog2(nsets) : 1;
  endfunction

endpackage

// File: rtl/cpuregs_map.sv
// Translates a {mode, set, reg} address into a storage entry index.
// It also flags stack pointer accesses that use the illegal mode.
module cpuregs_map
  import cpuregs_pkg::*;
#(
  parameter int NSETS = 2,
  parameter int SB    = 1,
  parameter int IW    = 4
) (
  input  logic [SB+4:0] addr,
  output logic [IW-1:0] idx,
  output logic          illegal
);

  localparam int KSP_IDX = 6 * NSETS;

  logic [1:0]    mode;
  logic [SB-1:0] set;
  logic [2:0]    rg;

  assign mode = addr[SB+4:SB+3];
  assign set  = addr[SB+2:3];
  assign rg   = addr[2:0];

  // The stack pointers and the PC sit above the general sets. An out-of-range set field wraps.
  always_comb begin
    idx     = '0;
    illegal = 1'b0;
    if (rg == REG_SP) begin
      case (mode)
        KERNEL, ILLEGAL: idx = IW'(KSP_IDX);
        SUPER:           idx = IW'(KSP_IDX + 1);
        default:         idx = IW'(KSP_IDX + 2);
      endcase
      illegal = (mode == ILLEGAL);
    end else if (rg == REG_PC) begin
      idx = IW'(KSP_IDX + 3);
    end else begin
      idx = IW'((int'(set) % NSETS) * 6 + int'(rg));
    end
  end

endmodule

// File: rtl/cpuregs_mp.sv
// Dual-read-port banked register file with registered reads and write-through bypass.
// A scrub sequencer clears every entry after reset before the core may use the file.
module cpuregs_mp
  import cpuregs_pkg::*;
#(
  parameter  int DW    = 16,
  parameter  int NSETS = 2,
  localparam int SB    = set_bits(NSETS),
  localparam int NREG  = nreg(NSETS),
  localparam int IW    = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [SB+4:0] raddr_a,
  input  logic [SB+4:0] raddr_b,
  input  logic [SB+4:0] waddr,
  input  logic [DW-1:0] d,
  input  logic          we,
  output logic [DW-1:0] oa,
  output logic [DW-1:0] ob,
  output logic          busy,
  output logic          mode_err,
  output logic [DW-1:0] datapath
);

  state_t state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_a, idx_b, idx_w, dp_idx;
  logic          ill_a, ill_b, ill_w;
  logic [DW-1:0] regs [NREG];

  cpuregs_map #(.NSETS(NSETS), .SB(SB), .IW(IW)) u_map_a (.addr(raddr_a), .idx(idx_a), .illegal(ill_a));
  cpuregs_map #(.NSETS(NSETS), .SB(SB), .IW(IW)) u_map_b (.addr(raddr_b), .idx(idx_b), .illegal(ill_b));
  cpuregs_map #(.NSETS(NSETS), .SB(SB), .IW(IW)) u_map_w (.addr(waddr),   .idx(idx_w), .illegal(ill_w));

  assign busy = (state_q == SCRUB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SCRUB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The last scrub write and the switch to RUN happen on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SCRUB: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IW'(NREG - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Storage is not reset. The scrub pass is what clears it.
  always_ff @(posedge clk) begin
    if (busy)
      regs[cnt_q] <= '0;
    else if (we)
      regs[idx_w] <= d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oa       <= '0;
      ob       <= '0;
      mode_err <= 1'b0;
    end else if (busy) begin
      oa       <= '0;
      ob       <= '0;
      mode_err <= 1'b0;
    end else begin
      oa       <= (we && idx_w == idx_a) ? d : regs[idx_a];
      ob       <= (we && idx_w == idx_b) ? d : regs[idx_b];
      mode_err <= ill_a | ill_b | (we & ill_w);
    end
  end

  assign dp_idx   = IW'((int'(raddr_a[SB+2:3]) % NSETS) * 6);
  assign datapath = regs[dp_idx];

endmodule
